sram_responder: RTL

- Memory-side responder for the SLC-3 SRAM bus. It is the other end of the active-low Mem_CE/Mem_OE/Mem_WE/Mem_UB/Mem_LB strobes that the CPU control unit drives.
- Provides an on-chip word memory with the same multi-cycle timing the CPU issues: 2 strobe-low cycles per read, 2 per write.
- Also provides one memory-mapped I/O word: switches on read, hex display register on write.
- Sits between the CPU datapath (MAR/MDR) and the board I/O; used on FPGA and in simulation in place of the external SRAM.

---
 rtl/sram_resp_pkg.sv | 21 ++
 rtl/byte_lane_merge.sv | 17 +
 rtl/sram_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and lane masks for the SLC-3 SRAM bus responder.
package sram_resp_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] LANE_HI = 16'hFF00;
    localparam logic [DATA_W-1:0] LANE_LO = 16'h00FF;

    typedef enum logic [1:0] {
        IDLE,
        RD_HOLD,
        WR_ARM,
        WR_DONE
    } state_e;

    // Strobes are active low: a high UB/LB disables that byte lane.
    function automatic logic [DATA_W-1:0] lane_mask(input logic ub, input logic lb);
        return (ub ? '0 : LANE_HI) | (lb ? '0 : LANE_LO);
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces only the enabled byte lanes of old_word with those of new_word.
module byte_lane_merge
    import sram_resp_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic              ub,
    input  logic              lb,
    output logic [DATA_W-1:0] merged_word
);

    logic [DATA_W-1:0] mask;

    assign mask        = lane_mask(ub, lb);
    assign merged_word = (new_word & mask) | (old_word & ~mask);

endmodule

// File: rtl/sram_responder.sv
// On-chip memory and I/O responder for the SLC-3 SRAM strobe bus.
// Define SRAM_RESP_PROT_EN to build the sticky protocol error flag on Err.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 10,
    parameter logic [ADDR_W-1:0] IO_ADDR = '1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Data_valid,
    input  logic [DATA_W-1:0] SW,
    output logic [DATA_W-1:0] HEX_out,
    output logic              Err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] data_q, hex_q;
    logic [DATA_W-1:0] rd_word, old_word, merged_word;
    logic              is_io, rd_req, wr_req, load_rd, commit;

    assign is_io    = (ADDR == IO_ADDR);
    assign rd_req   = !Mem_OE && Mem_WE;
    assign wr_req   = !Mem_WE;
    assign rd_word  = (is_io ? SW : mem[ADDR]) & lane_mask(Mem_UB, Mem_LB);
    assign old_word = is_io ? hex_q : mem[ADDR];

    byte_lane_merge u_merge (
        .old_word    (old_word),
        .new_word    (Data_from_CPU),
        .ub          (Mem_UB),
        .lb          (Mem_LB),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d = state_q;
        load_rd = 1'b0;
        commit  = 1'b0;
        if (Mem_CE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, RD_HOLD: begin
                    if (wr_req) begin
                        state_d = WR_ARM;
                    end else if (rd_req) begin
                        state_d = RD_HOLD;
                        load_rd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WR_ARM: begin
                    // WE must still be low on the second edge, otherwise the write is dropped.
                    if (wr_req) begin
                        state_d = WR_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WR_DONE: begin
                    if (wr_req) begin
                        state_d = WR_DONE;
                    end else if (rd_req) begin
                        state_d = RD_HOLD;
                        load_rd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_rd) begin
                data_q <= rd_word;
            end
            if (commit && is_io) begin
                hex_q <= merged_word;
            end
        end
    end

    // Contents survive reset, so the array sits outside the reset domain.
    always_ff @(posedge Clk) begin
        if (commit && !is_io) begin
            mem[ADDR] <= merged_word;
        end
    end

    assign Data_to_CPU = data_q;
    assign Data_valid  = (state_q == RD_HOLD);
    assign HEX_out     = hex_q;

`ifdef SRAM_RESP_PROT_EN
    logic err_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (!Mem_CE && ((!Mem_OE && !Mem_WE) || (state_q == WR_ARM && Mem_WE))) begin
            err_q <= 1'b1;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule
